rotor_slice_scheduler: RTL
==========================

# rotor_slice_scheduler

Angular sequencer for the rotating 16x16 LED display: measures rotor revolution time from the `cycle_marker` position pulse, divides each revolution into 2^SLICE_BITS equal angular slices, and tells the matrix driver which slice of the frame to show and when. It also owns the front/back frame-buffer select, flipping it only at a revolution boundary so a new frame never tears mid-rotation. It sits between the rotor sensor input and the frame store / `disp_matrix` path.

## Interface
- SLICE_BITS, 5, log2 of slices per revolution (32).
- PERIOD_W, 24, width of the period/timeout counter.
- MIN_PERIOD, 2048, shortest accepted revolution in clocks; must be ≥ 2^SLICE_BITS. Marks closer than this are glitches.
- MAX_PERIOD, 2^24-1, revolution timeout in clocks; must be > MIN_PERIOD and < 2^PERIOD_W.
- clock  in  1  single clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- cycle_marker  in  1  raw rotor index sensor, asynchronous, active high.
- swap_req  in  1  writer has a complete back-buffer frame; level, held until swap_ack.
- slice  out  SLICE_BITS  current angular slice index.
- slice_valid  out  1  high while locked; driver blanks row/col when low.
- slice_start  out  1  one-cycle pulse on the first cycle of every slice.
- buf_sel  out  1  frame buffer currently displayed.
- swap_ack  out  1  one-cycle pulse: buf_sel has just toggled.
- locked  out  1  state == RUN.
- stall  out  1  one-cycle pulse on timeout (rotor stopped/lost).

## Operation
- cycle_marker passes through a 2-flop synchronizer plus a rising-edge detector, yielding internal one-cycle `mark`.
- Period counter `cnt` (PERIOD_W) increments every cycle, saturates at MAX_PERIOD. Measured period P = cnt + 1 at the mark. A mark is valid iff MIN_PERIOD ≤ P < MAX_PERIOD.
- Slice length L = P >> SLICE_BITS (floor); the remainder is absorbed by the last slice.
- States:
  - IDLE: outputs blanked. mark → ACQUIRE, cnt := 0.
  - ACQUIRE: measuring the first revolution. Valid mark → RUN, latch L, slice := 0, sub := 0, cnt := 0. Mark with P < MIN_PERIOD is ignored (cnt keeps counting). cnt reaching MAX_PERIOD → IDLE, stall pulse.
  - RUN: sub counts 0..L-1; at sub == L-1, sub := 0 and slice increments. slice saturates at 2^SLICE_BITS-1 and holds (no wrap) until the next valid mark. Valid mark → re-latch L from the new P, slice := 0, sub := 0, cnt := 0. Glitch mark ignored. cnt reaching MAX_PERIOD → IDLE, stall, slice := 0.
- Mark and cnt == MAX_PERIOD in the same cycle: timeout wins, mark is dropped.
- Swap: in RUN, a valid mark with swap_req high toggles buf_sel and pulses swap_ack in the same cycle slice returns to 0. In IDLE/ACQUIRE a high swap_req is served on the next cycle (display is blank). The writer drops swap_req the cycle after swap_ack; if it is still high, that is a new request.
- Reset (reset_n low at an edge): state IDLE, cnt/sub/L/slice = 0; all outputs 0 including buf_sel; synchronizer cleared. Reset mid-revolution discards the measurement; relock needs two valid marks.

## Timing
- All outputs registered.
- cycle_marker first sampled high at edge k → mark internal at k+2 → state/slice/swap_ack/slice_start update at edge k+3.
- Entering RUN: slice_valid, locked, and slice_start rise together with slice = 0.
- Slice n starts n·L cycles after the mark update; slice_start pulses at each increment, not while slice is held at saturation.
- stall and the drop of slice_valid/locked occur on the same edge.

## Test plan
- Reset: hold reset_n low 4 cycles with cycle_marker toggling → all outputs 0, state IDLE.
- Lock, with MIN_PERIOD=64, MAX_PERIOD=4096, SLICE_BITS=5: marks every 1024 cycles → locked after 2nd mark + 3 cycles, L=32, slice steps 0..31 every 32 cycles, slice_start 32 pulses per revolution.
- Glitch: extra mark 10 cycles after a valid mark → ignored, slice continues, L unchanged.
- Slowdown and timeout: period 1024 then 1100 → slice holds at 31 for 76 cycles, then relocks with L=34. Stop marks → stall pulse 4096 cycles after the last mark, locked = 0.
- Swap: swap_req raised mid-revolution → swap_ack and buf_sel toggle exactly at the next slice := 0 update. swap_req raised in IDLE → ack on the next cycle.
- Reset mid-RUN at slice 17 → outputs clear immediately. Relock requires two further valid marks.

Source files
------------

// File: rtl/rotor_slice_scheduler.sv
// rotor_slice_scheduler: angular slice sequencer for the rotating LED display.
// Locks to the rotor index mark, paces slices and flips frame buffers per turn.
module rotor_slice_scheduler #(
    parameter int SLICE_BITS = 5,
    parameter int PERIOD_W   = 24,
    parameter int MIN_PERIOD = 2048,
    parameter int MAX_PERIOD = (1 << 24) - 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cycle_marker,
    input  logic                  swap_req,
    output logic [SLICE_BITS-1:0] slice,
    output logic                  slice_valid,
    output logic                  slice_start,
    output logic                  buf_sel,
    output logic                  swap_ack,
    output logic                  locked,
    output logic                  stall
);

    localparam int LEN_W = PERIOD_W - SLICE_BITS;

    localparam logic [PERIOD_W-1:0] CNT_MAX =
        PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W:0] P_MIN =
        (PERIOD_W + 1)'(MIN_PERIOD);
    localparam logic [PERIOD_W:0] P_MAX =
        (PERIOD_W + 1)'(MAX_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t state_q;

    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge history
    logic [2:0] sync_q;
    logic       mark_q;

    logic [PERIOD_W-1:0]   cnt_q;
    logic [PERIOD_W-1:0]   cnt_d;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      sub_q;
    logic [LEN_W-1:0]      sub_d;
    logic [SLICE_BITS-1:0] slice_q;
    logic [SLICE_BITS-1:0] slice_d;

    logic slice_valid_q;
    logic slice_start_q;
    logic buf_sel_q;
    logic swap_ack_q;
    logic locked_q;
    logic stall_q;

    logic [PERIOD_W:0] period;
    logic              timeout;
    logic              mark_ok;
    logic              sub_last;
    logic              slice_top;
    logic              swap_blank;

    // Synchronize the raw index sensor and turn its rising edge into a pulse
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q <= '0;
            mark_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], cycle_marker};
            mark_q <= sync_q[1] & ~sync_q[2];
        end
    end

    // Period measurement, mark qualification and slice pacing helpers
    always_comb begin
        period     = {1'b0, cnt_q} + 1'b1;
        timeout    = (cnt_q == CNT_MAX);
        cnt_d      = timeout ? cnt_q : cnt_q + 1'b1;
        mark_ok    = mark_q && !timeout
                     && (period >= P_MIN)
                     && (period < P_MAX);
        sub_last   = (sub_q == len_q - LEN_W'(1));
        sub_d      = sub_q + LEN_W'(1);
        slice_top  = (slice_q == {SLICE_BITS{1'b1}});
        slice_d    = slice_q + SLICE_BITS'(1);
        swap_blank = swap_req && !swap_ack_q;
    end

    // Lock state machine with registered slice, swap and status outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            len_q         <= '0;
            sub_q         <= '0;
            slice_q       <= '0;
            slice_valid_q <= 1'b0;
            slice_start_q <= 1'b0;
            buf_sel_q     <= 1'b0;
            swap_ack_q    <= 1'b0;
            locked_q      <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            slice_start_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            stall_q       <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (swap_blank) begin
                        buf_sel_q  <= ~buf_sel_q;
                        swap_ack_q <= 1'b1;
                    end
                    if (mark_q) begin
                        state_q <= ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (swap_blank) begin
                        buf_sel_q  <= ~buf_sel_q;
                        swap_ack_q <= 1'b1;
                    end
                    if (timeout) begin
                        state_q <= ST_IDLE;
                        stall_q <= 1'b1;
                        cnt_q   <= '0;
                    end else if (mark_ok) begin
                        state_q       <= ST_RUN;
                        len_q         <= period[PERIOD_W-1:SLICE_BITS];
                        sub_q         <= '0;
                        slice_q       <= '0;
                        cnt_q         <= '0;
                        slice_valid_q <= 1'b1;
                        locked_q      <= 1'b1;
                        slice_start_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_RUN: begin
                    if (timeout) begin
                        state_q       <= ST_IDLE;
                        stall_q       <= 1'b1;
                        cnt_q         <= '0;
                        sub_q         <= '0;
                        slice_q       <= '0;
                        slice_valid_q <= 1'b0;
                        locked_q      <= 1'b0;
                    end else if (mark_ok) begin
                        len_q         <= period[PERIOD_W-1:SLICE_BITS];
                        sub_q         <= '0;
                        slice_q       <= '0;
                        cnt_q         <= '0;
                        slice_start_q <= 1'b1;
                        if (swap_req) begin
                            buf_sel_q  <= ~buf_sel_q;
                            swap_ack_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        if (sub_last) begin
                            sub_q <= '0;
                            if (!slice_top) begin
                                slice_q       <= slice_d;
                                slice_start_q <= 1'b1;
                            end
                        end else begin
                            sub_q <= sub_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign slice       = slice_q;
    assign slice_valid = slice_valid_q;
    assign slice_start = slice_start_q;
    assign buf_sel     = buf_sel_q;
    assign swap_ack    = swap_ack_q;
    assign locked      = locked_q;
    assign stall       = stall_q;

endmodule
